decode_stage_hs: RTL and testbench

Parametrised decode stage for the in-order RISC-V pipeline. It sits between fetch and execute and contains the architectural register file. It decodes instruction fields, generates the sign-extended immediate, and reads operands with write-back bypass. It adds three capabilities to the earlier decode stage: valid/ready handshakes on both sides, a load-use interlock, and operand refresh while the stage is stalled.

---
 rtl/decode_stage_hs.sv | 222 ++++++++++++++++++++++
 tb/tb_decode_stage_hs.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_hs.sv
// Decode stage with valid/ready handshakes for the in-order RISC-V pipeline.
// Holds the architectural register file and decodes fields and the immediate.
// Operands are read with write-back bypass, and a load-use interlock stalls fetch.
// While execute stalls, a held bundle picks up write-backs to its source registers.
module decode_stage_hs #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int RAW  = 5,
  parameter int PCW  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  // fetch side
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PCW-1:0]  in_pc,
  // execute side
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [RAW-1:0]  rd,
  output logic [RAW-1:0]  rs1,
  output logic [RAW-1:0]  rs2,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic [XLEN-1:0] imm_ext,
  output logic [PCW-1:0]  out_pc,
  // load-use interlock
  input  logic            ex_is_load,
  input  logic [RAW-1:0]  ex_rd,
  // write-back port
  input  logic            wb_en,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  // debug / branch-resolve read port
  input  logic [RAW-1:0]  dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  // Base opcodes that matter for operand usage and immediate format.
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Everything handed to execute, registered as one unit.
  typedef struct packed {
    logic [6:0]      opcode;
    logic [RAW-1:0]  rd;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [XLEN-1:0] imm;
    logic [PCW-1:0]  pc;
  } bundle_t;

  // The bundle a killed or reset stage presents: an addi-class NOP with all fields zero.
  function automatic bundle_t nop_bundle();
    bundle_t b;
    b        = '0;
    b.opcode = OP_IMM;
    return b;
  endfunction

  // Sign-extended immediate for each instruction format; unknown opcodes give zero.
  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] inst);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      OP_STORE:
        imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:
        imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      OP_JAL:
        imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

  // State
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  bundle_t         bundle_q, bundle_d;
  logic            out_valid_q, out_valid_d;

  // Decode of the incoming instruction word
  logic [6:0]      in_opcode;
  logic [RAW-1:0]  in_rd, in_rs1, in_rs2;
  logic            uses_rs1, uses_rs2;
  logic            hazard, accept, rf_we;
  logic [XLEN-1:0] rs1_rdata, rs2_rdata;

  assign in_opcode = in_inst[6:0];
  assign in_rd     = RAW'(in_inst[11:7]);
  assign in_rs1    = RAW'(in_inst[19:15]);
  assign in_rs2    = RAW'(in_inst[24:20]);

  // x0 is hard-wired, so a write-back to it never lands in the array.
  assign rf_we = wb_en && (wb_rd != '0);

  // Which source registers the incoming opcode actually reads.
  always_comb begin
    // NOTE: every variable written here is given a value before any branch, so no path
    // leaves it unassigned and no latch can be inferred.
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (in_opcode)
      OP_OP, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // Load-use interlock against the instruction currently in execute.
  assign hazard = in_valid && ex_is_load && (ex_rd != '0) &&
                  ((uses_rs1 && (in_rs1 == ex_rd)) || (uses_rs2 && (in_rs2 == ex_rd)));

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Operand and debug reads: write-back data overrides the array for the same register.
  always_comb begin
    rs1_rdata = (in_rs1 == '0) ? '0 : rf_q[in_rs1];
    rs2_rdata = (in_rs2 == '0) ? '0 : rf_q[in_rs2];
    dbg_data  = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];
    if (rf_we && (wb_rd == in_rs1))   rs1_rdata = wb_data;
    if (rf_we && (wb_rd == in_rs2))   rs2_rdata = wb_data;
    if (rf_we && (wb_rd == dbg_addr)) dbg_data  = wb_data;
  end

  // Register file next state: one write port, x0 excluded by rf_we.
  always_comb begin
    rf_d = rf_q;
    if (rf_we) rf_d[wb_rd] = wb_data;
  end

  // Register file storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is a flop array with a defined post-reset state (all zero),
      // so it is cleared here like any other flop rather than left uninitialised as a RAM.
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Pipeline register next state: flush, then load, then bubble, then hold with refresh.
  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
      bundle_d    = nop_bundle();
    end else if (accept) begin
      out_valid_d     = 1'b1;
      bundle_d.opcode = in_opcode;
      bundle_d.rd     = in_rd;
      bundle_d.rs1    = in_rs1;
      bundle_d.rs2    = in_rs2;
      bundle_d.func3  = in_inst[14:12];
      bundle_d.func7  = in_inst[31:25];
      bundle_d.data1  = rs1_rdata;
      bundle_d.data2  = rs2_rdata;
      bundle_d.imm    = gen_imm(in_inst);
      bundle_d.pc     = in_pc;
    end else if (!out_valid_q || out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      // Stalled toward execute: keep the held operands current with write-back.
      if (rf_we && (wb_rd == bundle_q.rs1)) bundle_d.data1 = wb_data;
      if (rf_we && (wb_rd == bundle_q.rs2)) bundle_d.data2 = wb_data;
    end
  end

  // Pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state flops take non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      out_valid_q <= 1'b0;
      bundle_q    <= nop_bundle();
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = bundle_q.opcode;
  assign rd        = bundle_q.rd;
  assign rs1       = bundle_q.rs1;
  assign rs2       = bundle_q.rs2;
  assign func3     = bundle_q.func3;
  assign func7     = bundle_q.func7;
  assign data1     = bundle_q.data1;
  assign data2     = bundle_q.data2;
  assign imm_ext   = bundle_q.imm;
  assign out_pc    = bundle_q.pc;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Self-checking bench for decode_stage_hs: a table of single-instruction vectors,
// hand-written stall/flush/reset sequences, and a scoreboard on the execute handshake.
module tb_decode_stage_hs;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int RAW  = 5;
  localparam int PCW  = 64;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_inst;
  logic [PCW-1:0]  in_pc, out_pc;
  logic [6:0]      opcode, func7;
  logic [RAW-1:0]  rd, rs1, rs2, ex_rd, wb_rd, dbg_addr;
  logic [2:0]      func3;
  logic [XLEN-1:0] data1, data2, imm_ext, wb_data, dbg_data;
  logic            ex_is_load, wb_en;

  always #5 clk = ~clk;

  decode_stage_hs #(.XLEN(XLEN), .NREG(NREG), .RAW(RAW), .PCW(PCW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .func7(func7),
    .data1(data1), .data2(data2), .imm_ext(imm_ext), .out_pc(out_pc),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] d1, d2, imm, pc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_rf [NREG];

  function automatic logic [63:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (wb_en && wb_rd == a) return wb_data;
    return model_rf[a];
  endfunction

  function automatic logic [63:0] model_imm(input logic [31:0] x);
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    logic signed [63:0] r;
    i12 = x[31:20];
    s12 = {x[31:25], x[11:7]};
    b13 = {x[31], x[7], x[30:25], x[11:8], 1'b0};
    u32 = {x[31:12], 12'h000};
    j21 = {x[31], x[19:12], x[20], x[30:21], 1'b0};
    case (x[6:0])
      7'h13, 7'h03, 7'h67: r = i12;
      7'h23:               r = s12;
      7'h63:               r = b13;
      7'h37, 7'h17:        r = u32;
      7'h6F:               r = j21;
      default:             r = 64'sd0;
    endcase
    return r;
  endfunction

  // Scoreboard monitor, sampling mid-cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < NREG; i++) model_rf[i] = 64'd0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_opcode", 64'(opcode),  64'(e.op));
          check("sb_rd",     64'(rd),      64'(e.rd));
          check("sb_rs1",    64'(rs1),     64'(e.rs1));
          check("sb_rs2",    64'(rs2),     64'(e.rs2));
          check("sb_func3",  64'(func3),   64'(e.f3));
          check("sb_func7",  64'(func7),   64'(e.f7));
          check("sb_data1",  data1,        e.d1);
          check("sb_data2",  data2,        e.d2);
          check("sb_imm",    imm_ext,      e.imm);
          check("sb_pc",     out_pc,       e.pc);
        end
      end else if (out_valid && !out_ready && !flush && sb.size() != 0) begin
        e = sb.pop_front();
        if (wb_en && wb_rd != 5'd0 && wb_rd == e.rs1) e.d1 = wb_data;
        if (wb_en && wb_rd != 5'd0 && wb_rd == e.rs2) e.d2 = wb_data;
        sb.push_front(e);
      end
      if (flush) sb.delete();
      if (in_valid && in_ready) begin
        e.op  = in_inst[6:0];
        e.rd  = in_inst[11:7];
        e.rs1 = in_inst[19:15];
        e.rs2 = in_inst[24:20];
        e.f3  = in_inst[14:12];
        e.f7  = in_inst[31:25];
        e.d1  = model_read(in_inst[19:15]);
        e.d2  = model_read(in_inst[24:20]);
        e.imm = model_imm(in_inst);
        e.pc  = in_pc;
        sb.push_back(e);
      end
      if (wb_en && wb_rd != 5'd0) model_rf[wb_rd] = wb_data;
    end
  end

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  wrd;
    logic [63:0] wdata;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] d1, d2, imm;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // add x1,x5,x0 (x5 preloaded with 0x1234)
    vecs[0] = '{32'h000280B3, 1'b0, 5'd0,  64'h0,    7'h33, 5'd1,  5'd5, 5'd0,  3'd0, 7'h00, 64'h1234, 64'h0,    64'h0};
    // addi x2,x6,-1 with same-cycle write-back of x6
    vecs[1] = '{32'hFFF30113, 1'b1, 5'd6,  64'hAA,   7'h13, 5'd2,  5'd6, 5'd31, 3'd0, 7'h7F, 64'hAA,   64'h0,    64'hFFFF_FFFF_FFFF_FFFF};
    // beq x1,x2,-8 with rs2 bypass
    vecs[2] = '{32'hFE208CE3, 1'b1, 5'd2,  64'h77,   7'h63, 5'd25, 5'd1, 5'd2,  3'd0, 7'h7F, 64'h0,    64'h77,   64'hFFFF_FFFF_FFFF_FFF8};
    // jal x1,+2048 while write-back targets x0
    vecs[3] = '{32'h001000EF, 1'b1, 5'd0,  64'hDEAD, 7'h6F, 5'd1,  5'd0, 5'd1,  3'd0, 7'h00, 64'h0,    64'h0,    64'h800};
    // lui x3,0x80000
    vecs[4] = '{32'h800001B7, 1'b0, 5'd0,  64'h0,    7'h37, 5'd3,  5'd0, 5'd0,  3'd0, 7'h40, 64'h0,    64'h0,    64'hFFFF_FFFF_8000_0000};
    // sw x5,12(x6)
    vecs[5] = '{32'h00532623, 1'b0, 5'd0,  64'h0,    7'h23, 5'd12, 5'd6, 5'd5,  3'd2, 7'h00, 64'hAA,   64'h1234, 64'hC};
    // fence-class opcode: immediate must be zero; bypass on x31
    vecs[6] = '{32'hFFF0000F, 1'b1, 5'd31, 64'h31,   7'h0F, 5'd0,  5'd0, 5'd31, 3'd0, 7'h7F, 64'h0,    64'h31,   64'h0};
    // jalr x1,-4(x5)
    vecs[7] = '{32'hFFC280E7, 1'b0, 5'd0,  64'h0,    7'h67, 5'd1,  5'd5, 5'd28, 3'd0, 7'h7F, 64'h1234, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = '0;
    out_ready = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; dbg_addr = '0;

    // ---- reset state ----
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_opcode",    64'(opcode),    64'h13);
    check("rst_rd",        64'(rd),        64'd0);
    check("rst_rs1",       64'(rs1),       64'd0);
    check("rst_data1",     data1,          64'd0);
    check("rst_data2",     data2,          64'd0);
    check("rst_imm",       imm_ext,        64'd0);
    check("rst_pc",        out_pc,         64'd0);
    rst = 1'b0;
    tick();

    // ---- preload x5 through write-back; debug port bypass then array read ----
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234; dbg_addr = 5'd5;
    #1 check("dbg_bypass", dbg_data, 64'h1234);
    tick();
    wb_en = 1'b0;
    #1 check("dbg_rf_read", dbg_data, 64'h1234);

    // ---- table-driven vectors, one per cycle, out_ready held high ----
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = 64'h1000 + 64'(4 * i);
      wb_en = vecs[i].wen; wb_rd = vecs[i].wrd; wb_data = vecs[i].wdata;
      #1 check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0; wb_en = 1'b0;
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_opcode", i),    64'(opcode),    64'(vecs[i].op));
      check($sformatf("vec%0d_rd", i),        64'(rd),        64'(vecs[i].rd));
      check($sformatf("vec%0d_rs1", i),       64'(rs1),       64'(vecs[i].rs1));
      check($sformatf("vec%0d_rs2", i),       64'(rs2),       64'(vecs[i].rs2));
      check($sformatf("vec%0d_func3", i),     64'(func3),     64'(vecs[i].f3));
      check($sformatf("vec%0d_func7", i),     64'(func7),     64'(vecs[i].f7));
      check($sformatf("vec%0d_data1", i),     data1,          vecs[i].d1);
      check($sformatf("vec%0d_data2", i),     data2,          vecs[i].d2);
      check($sformatf("vec%0d_imm", i),       imm_ext,        vecs[i].imm);
      check($sformatf("vec%0d_pc", i),        out_pc,         64'h1000 + 64'(4 * i));
    end

    // ---- load-use interlock: add x3,x7,x1 behind a load to x7 ----
    in_valid = 1'b1; in_inst = 32'h001381B3; in_pc = 64'h2000;
    ex_is_load = 1'b1; ex_rd = 5'd7;
    #1 check("lu_rs1_stall", 64'(in_ready), 64'd0);
    tick();
    check("lu_bubble_valid",  64'(out_valid), 64'd0);
    check("lu_bubble_hold_rd", 64'(rd),       64'd1);
    check("lu_bubble_hold_op", 64'(opcode),   64'h67);
    ex_rd = 5'd1;
    #1 check("lu_rs2_stall", 64'(in_ready), 64'd1 - 64'd1);
    ex_rd = 5'd3;
    #1 check("lu_rd_no_stall", 64'(in_ready), 64'd1);
    ex_is_load = 1'b0;
    tick();
    check("lu_accept_valid", 64'(out_valid), 64'd1);
    check("lu_accept_rd",    64'(rd),        64'd3);
    check("lu_accept_rs1",   64'(rs1),       64'd7);

    // ---- hold with operand refresh: add x4,x8,x9 stalled by execute ----
    in_inst = 32'h00940233; in_pc = 64'h2004;
    #1 check("hold_accept_ready", 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b0;
    in_inst = 32'h800001B7; in_pc = 64'h2008;
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h55;
    #1 check("hold_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("hold_valid",      64'(out_valid), 64'd1);
    check("hold_data2_ref",  data2,          64'h55);
    check("hold_data1",      data1,          64'h0);
    check("hold_rd",         64'(rd),        64'd4);
    check("hold_rs2",        64'(rs2),       64'd9);
    check("hold_pc",         out_pc,         64'h2004);
    wb_rd = 5'd8; wb_data = 64'h66;
    tick();
    check("hold_data1_ref",  data1,          64'h66);
    check("hold_data2_keep", data2,          64'h55);
    wb_rd = 5'd10; wb_data = 64'h99;
    tick();
    check("hold_unrelated_d1", data1, 64'h66);
    check("hold_unrelated_d2", data2, 64'h55);
    wb_en = 1'b0; out_ready = 1'b1;
    #1 check("hold_release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("hold_next_valid", 64'(out_valid), 64'd1);
    check("hold_next_op",    64'(opcode),    64'h37);
    check("hold_next_imm",   imm_ext,        64'hFFFF_FFFF_8000_0000);

    // ---- flush during hold, with a simultaneous hazard and a write-back ----
    out_ready = 1'b0;
    tick();
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h001381B3; in_pc = 64'h3000;
    ex_is_load = 1'b1; ex_rd = 5'd7;
    wb_en = 1'b1; wb_rd = 5'd11; wb_data = 64'hF00D;
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; ex_is_load = 1'b0; wb_en = 1'b0;
    check("flush_valid",  64'(out_valid), 64'd0);
    check("flush_opcode", 64'(opcode),    64'h13);
    check("flush_rd",     64'(rd),        64'd0);
    check("flush_func7",  64'(func7),     64'd0);
    check("flush_data1",  data1,          64'd0);
    check("flush_imm",    imm_ext,        64'd0);
    check("flush_pc",     out_pc,         64'd0);
    dbg_addr = 5'd11;
    #1 check("flush_rf_written", dbg_data, 64'hF00D);

    // ---- writes to x0 are ignored ----
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hBEEF; dbg_addr = 5'd0;
    #1 check("x0_bypass_zero", dbg_data, 64'd0);
    tick();
    wb_en = 1'b0;
    #1 check("x0_rf_zero", dbg_data, 64'd0);

    // ---- reset in the middle of a stall ----
    in_valid = 1'b1; in_inst = 32'h000280B3; in_pc = 64'h4000; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_data1", data1,          64'h1234);
    tick();
    #1 rst = 1'b1;
    #1;
    check("rst_stall_valid",  64'(out_valid), 64'd0);
    check("rst_stall_data1",  data1,          64'd0);
    check("rst_stall_opcode", 64'(opcode),    64'h13);
    check("rst_stall_pc",     out_pc,         64'd0);
    dbg_addr = 5'd5;
    #1 check("rst_rf_clear", dbg_data, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
